// File: rtl/axi_rr_arb_ptr.sv
// Round-robin arbiter with a registered priority pointer and optional burst lock.
// The winner is combinational; the pointer and the lock only move on a completed transfer.
module axi_rr_arb_ptr #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter int STEP_MODE = 0,
    parameter int LOCK_EN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic             last_i,
    input  logic             gnt_i,
    output logic             valid_o,
    output logic [N_REQ-1:0] gnt_o,
    output logic [WIDTH-1:0] sel_o,
    output logic [WIDTH-1:0] rr_flag_o,
    output logic             locked_o
);

    // Index width large enough to hold pointer + offset (up to 2*N_REQ-2)
    localparam int IW = $clog2(2 * N_REQ);
    localparam logic [IW-1:0]    LAST_IDX   = IW'(N_REQ - 1);
    localparam logic [WIDTH-1:0] LAST_FLAG  = WIDTH'(N_REQ - 1);

    logic [WIDTH-1:0]   rr_flag_reg, rr_flag_next;
    logic               locked_reg, locked_next;
    logic [WIDTH-1:0]   lock_idx_reg, lock_idx_next;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   rot_req;
    logic [IW-1:0]      rr_ext;
    logic [IW-1:0]      offset;
    logic               hit;
    logic [IW-1:0]      win_sum;
    logic [IW-1:0]      rr_win;
    logic [IW-1:0]      cand_idx;
    logic               cand_valid;
    logic               eff_last;
    logic               transfer;

    function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] x);
        return (x == LAST_FLAG) ? '0 : x + WIDTH'(1);
    endfunction

    // Requests rotated so that bit 0 is the requester at the pointer
    assign req_dbl = {req_i, req_i};
    assign rr_ext  = IW'(rr_flag_reg);

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot_req[gi] = req_dbl[rr_ext + IW'(gi)];
        end
    endgenerate

    always_comb begin
        offset = '0;
        hit    = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                offset = IW'(k);
                hit    = 1'b1;
            end
        end
    end

    assign win_sum = rr_ext + offset;
    assign rr_win  = (win_sum > LAST_IDX) ? (win_sum - IW'(N_REQ)) : win_sum;

    // Output process: a held burst overrides the rotating scan
    always_comb begin
        cand_idx   = rr_win;
        cand_valid = hit;
        if (locked_reg) begin
            cand_idx   = IW'(lock_idx_reg);
            cand_valid = req_i[lock_idx_reg];
        end
        valid_o = cand_valid;
        sel_o   = cand_valid ? WIDTH'(cand_idx) : '0;
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
            assign gnt_o[gi] = valid_o && (sel_o == WIDTH'(gi));
        end
    endgenerate

    assign eff_last  = (LOCK_EN == 0) || last_i;
    assign transfer  = valid_o && gnt_i;
    assign rr_flag_o = rr_flag_reg;
    assign locked_o  = locked_reg;

    // Next-state process
    always_comb begin
        rr_flag_next  = rr_flag_reg;
        locked_next   = locked_reg;
        lock_idx_next = lock_idx_reg;
        if (transfer) begin
            if (eff_last) begin
                locked_next  = 1'b0;
                rr_flag_next = (STEP_MODE != 0) ? wrap_inc(rr_flag_reg) : wrap_inc(sel_o);
            end else begin
                locked_next   = 1'b1;
                lock_idx_next = sel_o;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_flag_reg  <= '0;
            locked_reg   <= 1'b0;
            lock_idx_reg <= '0;
        end else begin
            rr_flag_reg  <= rr_flag_next;
            locked_reg   <= locked_next;
            lock_idx_reg <= lock_idx_next;
        end
    end

endmodule

// File: tb/tb_axi_rr_arb_ptr.sv
// Directed bench for axi_rr_arb_ptr: a 4-requester lock-enabled instance and a
// 3-requester legacy-step instance, with hand-computed expectations.
module tb_axi_rr_arb_ptr;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       last;
    logic       gnt_in;
    logic       valid;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [1:0] flag;
    logic       locked;

    logic       rst_b;
    logic [2:0] req_b;
    logic       last_b;
    logic       gnt_in_b;
    logic       valid_b;
    logic [2:0] gnt_b;
    logic [1:0] sel_b;
    logic [1:0] flag_b;
    logic       locked_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_rr_arb_ptr #(.N_REQ(4), .STEP_MODE(0), .LOCK_EN(1)) dut (
        .clk(clk), .rst(rst), .req_i(req), .last_i(last), .gnt_i(gnt_in),
        .valid_o(valid), .gnt_o(gnt), .sel_o(sel), .rr_flag_o(flag), .locked_o(locked)
    );

    axi_rr_arb_ptr #(.N_REQ(3), .STEP_MODE(1), .LOCK_EN(1)) dut_b (
        .clk(clk), .rst(rst_b), .req_i(req_b), .last_i(last_b), .gnt_i(gnt_in_b),
        .valid_o(valid_b), .gnt_o(gnt_b), .sel_o(sel_b), .rr_flag_o(flag_b), .locked_o(locked_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs shortly after a rising edge and let combinational outputs settle
    task automatic drive(input logic r, input logic [3:0] rq, input logic l, input logic g);
        rst = r; req = rq; last = l; gnt_in = g;
        #1;
    endtask

    int exp_sel[5]  = '{0, 1, 2, 3, 0};
    int exp_flag[5] = '{1, 2, 3, 0, 1};

    initial begin
        rst = 1'b1; req = 4'b1111; last = 1'b1; gnt_in = 1'b1;
        rst_b = 1'b1; req_b = 3'b000; last_b = 1'b1; gnt_in_b = 1'b0;

        // Reset for two cycles; second cycle has last=0 so a non-prioritised reset would lock
        tick();
        drive(1'b1, 4'b1111, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'b1111, 1'b1, 1'b0);
        rst_b = 1'b0;
        chk("rst_flag", 64'(flag), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_gnt", 64'(gnt), 64'b0001);
        chk("rst_sel", 64'(sel), 64'd0);

        // Full rotation, single-beat transfers
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'b1111, 1'b1, 1'b1);
            chk("rot_sel", 64'(sel), 64'(exp_sel[i]));
            tick();
            chk("rot_flag", 64'(flag), 64'(exp_flag[i]));
        end

        // Stall: pointer at 1, no acceptance
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'b1111, 1'b1, 1'b0);
            chk("stall_valid", 64'(valid), 64'd1);
            chk("stall_sel", 64'(sel), 64'd1);
            tick();
            chk("stall_flag", 64'(flag), 64'd1);
        end

        // Bring pointer back to 0, then skip over idle requesters
        drive(1'b1, 4'b0000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 4'b1010, 1'b1, 1'b1);
        chk("skip_flag0", 64'(flag), 64'd0);
        chk("skip_sel1", 64'(sel), 64'd1);
        chk("skip_gnt1", 64'(gnt), 64'b0010);
        tick();
        chk("skip_flag2", 64'(flag), 64'd2);
        drive(1'b0, 4'b1010, 1'b1, 1'b1);
        chk("skip_sel3", 64'(sel), 64'd3);
        chk("skip_gnt3", 64'(gnt), 64'b1000);
        tick();
        chk("skip_wrap", 64'(flag), 64'd0);

        // No requests: no winner, no state change despite gnt_i
        drive(1'b0, 4'b0000, 1'b1, 1'b1);
        chk("idle_valid", 64'(valid), 64'd0);
        chk("idle_gnt", 64'(gnt), 64'd0);
        chk("idle_sel", 64'(sel), 64'd0);
        tick();
        chk("idle_flag", 64'(flag), 64'd0);

        // Lock on requester 0
        drive(1'b0, 4'b1111, 1'b0, 1'b1);
        chk("lk_sel_a", 64'(sel), 64'd0);
        tick();
        chk("lk_locked", 64'(locked), 64'd1);
        chk("lk_flag", 64'(flag), 64'd0);
        drive(1'b0, 4'b1111, 1'b0, 1'b1);
        chk("lk_sel_b", 64'(sel), 64'd0);
        tick();
        drive(1'b0, 4'b1110, 1'b0, 1'b1);
        chk("lk_drop_val", 64'(valid), 64'd0);
        chk("lk_drop_gnt", 64'(gnt), 64'd0);
        tick();
        chk("lk_hold", 64'(locked), 64'd1);
        chk("lk_hold_flag", 64'(flag), 64'd0);
        drive(1'b0, 4'b1111, 1'b0, 1'b1);
        chk("lk_sel_c", 64'(sel), 64'd0);
        chk("lk_gnt_c", 64'(gnt), 64'b0001);
        tick();
        drive(1'b0, 4'b1111, 1'b1, 1'b1);
        chk("lk_sel_last", 64'(sel), 64'd0);
        tick();
        chk("lk_unlocked", 64'(locked), 64'd0);
        chk("lk_flag_end", 64'(flag), 64'd1);

        // Lock on requester 1, then reset mid-burst
        drive(1'b0, 4'b1111, 1'b0, 1'b1);
        chk("lk1_sel", 64'(sel), 64'd1);
        tick();
        drive(1'b0, 4'b1101, 1'b0, 1'b1);
        chk("lk1_locked", 64'(locked), 64'd1);
        chk("lk1_valid", 64'(valid), 64'd0);
        drive(1'b1, 4'b1111, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'b1111, 1'b1, 1'b0);
        chk("mid_locked", 64'(locked), 64'd0);
        chk("mid_flag", 64'(flag), 64'd0);
        chk("mid_gnt", 64'(gnt), 64'b0001);

        // Legacy counter mode, N_REQ=3: pointer steps by one regardless of winner
        req_b = 3'b100; last_b = 1'b1; gnt_in_b = 1'b1;
        #1;
        chk("b_sel2", 64'(sel_b), 64'd2);
        tick();
        chk("b_flag1", 64'(flag_b), 64'd1);
        req_b = 3'b111;
        #1;
        chk("b_sel1", 64'(sel_b), 64'd1);
        tick();
        chk("b_flag2", 64'(flag_b), 64'd2);
        #1;
        chk("b_sel_at2", 64'(sel_b), 64'd2);
        tick();
        chk("b_wrap", 64'(flag_b), 64'd0);
        gnt_in_b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rr_arb_ptr.md
AXI_RR_ARB_PTR -- requirements
Module: axi_rr_arb_ptr

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (legal range 1..64).
REQ-002 SHALL have parameter WIDTH, default max(1, clog2(N_REQ)), width of pointer and index outputs.
REQ-003 SHALL have parameter STEP_MODE, default 0. 0 = pointer moves to winner+1. 1 = pointer increments by one per completed grant (legacy counter behaviour).
REQ-004 SHALL have parameter LOCK_EN, default 1. 1 = multi-beat lock honoured. 0 = last_i ignored and treated as 1.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset is synchronous and active-high.
REQ-007 SHALL have port req_i  input  N_REQ  per-requester request.
REQ-008 SHALL have port last_i  input  1  current beat is last of the burst.
REQ-009 SHALL have port gnt_i  input  1  downstream accepts the current beat.
REQ-010 SHALL have port valid_o  output  1  a winner exists.
REQ-011 SHALL have port gnt_o  output  N_REQ  one-hot winner, all-zero when valid_o=0.
REQ-012 SHALL have port sel_o  output  WIDTH  binary winner index, 0 when valid_o=0.
REQ-013 SHALL have port rr_flag_o  output  WIDTH  registered priority pointer.
REQ-014 SHALL have port locked_o  output  1  registered, arbitration frozen on a burst.

Function
REQ-015 SHALL compute valid_o, gnt_o and sel_o combinationally from the current-cycle inputs and state (zero latency).
REQ-016 SHALL, when unlocked, select as winner the first requesting index scanning from rr_flag_o upward, modulo N_REQ.
REQ-017 SHALL drive valid_o = OR of req_i when unlocked.
REQ-018 SHALL define a transfer as valid_o & gnt_i. No state changes without a transfer, except on reset.
REQ-019 SHALL, on a transfer with effective last_i=1 and STEP_MODE=0, load rr_flag_o with (sel_o+1), wrapping to 0 when sel_o=N_REQ-1.
REQ-020 SHALL, on a transfer with effective last_i=1 and STEP_MODE=1, load rr_flag_o with rr_flag_o+1, wrapping to 0 when rr_flag_o=N_REQ-1.
REQ-021 SHALL wrap at N_REQ-1, not at 2^WIDTH-1, for non-power-of-two N_REQ; rr_flag_o SHALL never exceed N_REQ-1.
REQ-022 SHALL, on a transfer with LOCK_EN=1 and last_i=0, set locked_o and capture sel_o as the locked index; rr_flag_o is unchanged.
REQ-023 SHALL, while locked:
  - treat the locked index as the only candidate, ignoring other requests;
  - drive valid_o = req_i[locked index].
REQ-024 SHALL keep the lock when the locked requester deasserts req_i; valid_o is 0 until it reasserts.
REQ-025 SHALL, on a locked transfer with last_i=1, clear locked_o and update rr_flag_o per REQ-019/020 using the locked index as sel_o.
REQ-026 SHALL, when N_REQ=1, hold rr_flag_o at 0; gnt_o equals req_i in that case.
REQ-027 SHALL produce no X on outputs for any req_i pattern, including all-zero.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, set rr_flag_o=0, locked_o=0 and the locked index to 0.
REQ-029 SHALL give rst priority over any simultaneous transfer.
REQ-030 SHALL, on reset mid-burst, drop the lock; the next cycle arbitrates normally from index 0.

Verification (N_REQ=4, STEP_MODE=0, LOCK_EN=1 unless stated)
REQ-031 SHALL cover reset: rst=1 for 2 cycles with req_i=1111, gnt_i=1 -> after release rr_flag_o=0, locked_o=0, gnt_o=0001, sel_o=0.
REQ-032 SHALL cover full rotation: req_i=1111, gnt_i=1, last_i=1 for 5 cycles -> sel_o 0,1,2,3,0 and rr_flag_o 1,2,3,0,1.
REQ-033 SHALL cover skip: rr_flag_o=0, req_i=1010, single-beat transfers -> sel_o=1 then flag=2; sel_o=3 then flag=0.
REQ-034 SHALL cover lock:
  - req_i=1111, flag=0, transfer with last_i=0 -> locked_o=1;
  - 3 further beats -> sel_o=0 each, including one cycle with req_i[0]=0 giving valid_o=0;
  - last_i=1 beat -> locked_o=0, rr_flag_o=1.
REQ-035 SHALL cover stall and legacy wrap:
  - valid_o=1 with gnt_i=0 for 4 cycles -> rr_flag_o unchanged;
  - N_REQ=3, STEP_MODE=1, flag=2, transfer -> flag=0.
REQ-036 SHALL cover reset mid-lock: rst=1 during a burst -> locked_o=0, rr_flag_o=0 next cycle.
